// File: rtl/song_reader.sv
// Song sequencer: walks a registered song ROM one {note, duration} entry at a time,
// strobes each entry to note_player and waits for its note_done before advancing.
//
// state  | meaning
// IDLE   | stopped, waiting for play to start a song
// FETCH  | ROM address presented for the current entry
// DECODE | ROM data valid; load the note or detect the end marker
// LOAD   | new_note strobe cycle
// WAIT   | note_player is sounding the note; waiting for note_done
// HALT   | song finished; held until play drops to stop auto-replay
module song_reader #(
  parameter int IDX_BITS  = 5,
  parameter int SONG_BITS = 2
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_play,
  input  logic [SONG_BITS-1:0]          i_song,
  input  logic                          i_note_done,
  output logic [SONG_BITS+IDX_BITS-1:0] o_rom_addr,
  input  logic [11:0]                   i_rom_data,
  output logic [5:0]                    o_note_out,
  output logic [5:0]                    o_dur_out,
  output logic                          o_new_note,
  output logic                          o_song_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    LOAD   = 3'd3,
    WAIT   = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [IDX_BITS-1:0] IDX_LAST = '1;
  localparam logic [IDX_BITS-1:0] IDX_ZERO = '0;
  localparam logic [IDX_BITS-1:0] IDX_ONE  = {{(IDX_BITS-1){1'b0}}, 1'b1};

  state_t               r_state;
  logic [IDX_BITS-1:0]  r_idx;
  logic [SONG_BITS-1:0] r_song;
  logic [5:0]           r_note;
  logic [5:0]           r_dur;
  logic                 r_new_note;
  logic                 r_song_done;

  state_t               w_state_nxt;
  logic [IDX_BITS-1:0]  w_idx_nxt;
  logic [SONG_BITS-1:0] w_song_nxt;
  logic [5:0]           w_note_nxt;
  logic [5:0]           w_dur_nxt;
  logic                 w_new_note_nxt;
  logic                 w_song_done_nxt;
  logic                 w_song_change;

  assign w_song_change = (r_state != IDLE) && (r_state != HALT) && (i_song != r_song);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_idx       <= IDX_ZERO;
      r_song      <= '0;
      r_note      <= 6'd0;
      r_dur       <= 6'd0;
      r_new_note  <= 1'b0;
      r_song_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_song      <= w_song_nxt;
      r_note      <= w_note_nxt;
      r_dur       <= w_dur_nxt;
      r_new_note  <= w_new_note_nxt;
      r_song_done <= w_song_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_song_nxt      = r_song;
    w_note_nxt      = r_note;
    w_dur_nxt       = r_dur;
    w_new_note_nxt  = 1'b0;
    w_song_done_nxt = 1'b0;

    // A song change restarts from entry 0 and outranks a concurrent note_done.
    if (w_song_change) begin
      w_state_nxt = FETCH;
      w_song_nxt  = i_song;
      w_idx_nxt   = IDX_ZERO;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_play) begin
            w_state_nxt = FETCH;
            w_song_nxt  = i_song;
            w_idx_nxt   = IDX_ZERO;
          end
        end
        FETCH: begin
          if (i_play) w_state_nxt = DECODE;
        end
        DECODE: begin
          if (i_play) begin
            if (i_rom_data[5:0] == 6'd0) begin
              w_state_nxt     = HALT;
              w_song_done_nxt = 1'b1;
            end else begin
              w_note_nxt     = i_rom_data[11:6];
              w_dur_nxt      = i_rom_data[5:0];
              w_new_note_nxt = 1'b1;
              w_state_nxt    = LOAD;
            end
          end
        end
        LOAD: begin
          if (i_play) w_state_nxt = WAIT;
        end
        WAIT: begin
          if (i_note_done) begin
            if (r_idx == IDX_LAST) begin
              w_state_nxt     = HALT;
              w_song_done_nxt = 1'b1;
              w_idx_nxt       = IDX_ZERO;
            end else begin
              w_idx_nxt   = r_idx + IDX_ONE;
              w_state_nxt = FETCH;
            end
          end
        end
        HALT: begin
          if (!i_play) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign o_rom_addr  = {r_song, r_idx};
  assign o_note_out  = r_note;
  assign o_dur_out   = r_dur;
  assign o_new_note  = r_new_note;
  assign o_song_done = r_song_done;

endmodule

// File: tb/tb_song_reader.sv
// Directed-plus-random bench for song_reader: a randomly filled ROM array is the
// reference; expected strobes, addresses and song ends are derived from its contents.
module tb_song_reader;

  logic        clk;
  logic        reset_n;
  logic        play;
  logic [1:0]  song;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note_out;
  logic [5:0]  dur_out;
  logic        new_note;
  logic        song_done;

  logic [11:0] rom [128];
  int errors = 0;
  int checks = 0;

  song_reader #(.IDX_BITS(5), .SONG_BITS(2)) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_play      (play),
    .i_song      (song),
    .i_note_done (note_done),
    .o_rom_addr  (rom_addr),
    .i_rom_data  (rom_data),
    .o_note_out  (note_out),
    .o_dur_out   (dur_out),
    .o_new_note  (new_note),
    .o_song_done (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ROM: data follows the address by one clock.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_strobe(input int s, input int i);
    int a;
    logic [11:0] e;
    a = s * 32 + i;
    e = rom[a];
    chk("strobe", new_note, 1);
    chk("strobe_no_done", song_done, 0);
    chk("note_out", note_out, e[11:6]);
    chk("dur_out", dur_out, e[5:0]);
    chk("strobe_addr", rom_addr, a);
  endtask

  task automatic start_song(input int s);
    song = s[1:0];
    play = 1'b1;
    step();
    chk("fetch_addr", rom_addr, s * 32);
    chk("fetch_no_strobe", new_note, 0);
    step();
    chk("decode_no_strobe", new_note, 0);
    step();
    expect_strobe(s, 0);
  endtask

  // Entered in the strobe cycle of entry 0; plays the song to its end and stops it.
  task automatic run_from(input int s);
    int i;
    int d;
    bit pz;
    logic [11:0] e;
    i = 0;
    while (1) begin
      if ($urandom_range(0, 3) == 0) note_done = 1'b1;
      step();
      note_done = 1'b0;
      chk("strobe_len", new_note, 0);
      d = $urandom_range(0, 3);
      repeat (d) begin
        step();
        chk("wait_quiet", new_note | song_done, 0);
      end
      pz = ($urandom_range(0, 3) == 0);
      note_done = 1'b1;
      if (pz) play = 1'b0;
      step();
      note_done = 1'b0;
      if (i == 31) begin
        chk("wrap_done", song_done, 1);
        chk("wrap_no_strobe", new_note, 0);
        chk("wrap_idx", rom_addr, s * 32);
        break;
      end
      chk("next_addr", rom_addr, s * 32 + i + 1);
      chk("next_no_strobe", new_note | song_done, 0);
      if (pz) begin
        step();
        chk("paused_fetch", new_note, 0);
        chk("paused_addr", rom_addr, s * 32 + i + 1);
        play = 1'b1;
      end
      step();
      chk("decode_quiet", new_note | song_done, 0);
      step();
      e = rom[s * 32 + i + 1];
      if (e[5:0] == 6'd0) begin
        chk("marker_done", song_done, 1);
        chk("marker_no_strobe", new_note, 0);
        break;
      end
      expect_strobe(s, i + 1);
      i++;
    end
    step();
    chk("done_len", song_done, 0);
    repeat (3) begin
      step();
      chk("halt_quiet", new_note | song_done, 0);
    end
    play = 1'b0;
    step();
    step();
    chk("idle_quiet", new_note, 0);
  endtask

  initial begin
    logic [11:0] w;
    int mk;
    reset_n   = 1'b0;
    play      = 1'b0;
    song      = 2'd0;
    note_done = 1'b0;
    for (int a = 0; a < 128; a++) begin
      w[11:6] = 6'($urandom_range(0, 63));
      w[5:0]  = 6'($urandom_range(1, 63));
      rom[a]  = w;
    end
    rom[2]  = 12'h000 | 12'($urandom_range(0, 63) << 6);
    rom[32] = {6'd20, 6'd4};
    rom[33] = {6'd0, 6'($urandom_range(1, 63))};
    mk = $urandom_range(3, 8);
    rom[32 + mk] = rom[32 + mk] & 12'hFC0;
    mk = $urandom_range(2, 6);
    rom[64 + mk] = rom[64 + mk] & 12'hFC0;

    repeat (2) @(negedge clk);
    chk("rst_new_note", new_note, 0);
    chk("rst_song_done", song_done, 0);
    chk("rst_note", note_out, 0);
    chk("rst_dur", dur_out, 0);
    chk("rst_addr", rom_addr, 0);
    reset_n = 1'b1;
    step();
    chk("idle_hold", new_note, 0);

    // Basic fetch of song 1 entry 0, then reset while waiting on entry 1.
    start_song(1);
    chk("basic_note", note_out, 20);
    chk("basic_dur", dur_out, 4);
    step();
    chk("basic_strobe_len", new_note, 0);
    note_done = 1'b1;
    step();
    note_done = 1'b0;
    chk("basic_next_addr", rom_addr, 7'h21);
    step();
    step();
    expect_strobe(1, 1);
    step();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_new_note", new_note, 0);
    chk("mid_rst_song_done", song_done, 0);
    chk("mid_rst_note", note_out, 0);
    chk("mid_rst_dur", dur_out, 0);
    chk("mid_rst_addr", rom_addr, 0);
    @(negedge clk);
    play = 1'b0;
    reset_n = 1'b1;
    repeat (3) begin
      step();
      chk("post_rst_quiet", new_note, 0);
      chk("post_rst_addr", rom_addr, 0);
    end

    // Song 0 ends on the marker at entry 2.
    start_song(0);
    run_from(0);

    // Pause in FETCH, then change 0 -> 2 during WAIT together with note_done.
    song = 2'd0;
    play = 1'b1;
    step();
    chk("pause_fetch_addr", rom_addr, 0);
    play = 1'b0;
    repeat (3) begin
      step();
      chk("pause_no_strobe", new_note, 0);
      chk("pause_addr", rom_addr, 0);
    end
    play = 1'b1;
    step();
    chk("resume_decode", new_note, 0);
    step();
    expect_strobe(0, 0);
    step();
    chk("pre_change_quiet", new_note, 0);
    song = 2'd2;
    note_done = 1'b1;
    step();
    note_done = 1'b0;
    chk("change_addr", rom_addr, 7'h40);
    chk("change_no_strobe", new_note | song_done, 0);
    step();
    chk("change_decode", new_note, 0);
    step();
    expect_strobe(2, 0);
    run_from(2);

    // Song 3 has no marker: all 32 entries, then wrap to HALT.
    start_song(3);
    run_from(3);

    // Replay song 1 from IDLE.
    start_song(1);
    run_from(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
